// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and fetch stage in front of a combinational
//               instruction memory. Captures the returned word and its PC
//               into a valid/ready output register, follows branch/jump
//               redirects, stops on ECALL/EBREAK and on misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_out,
    input  logic [31:0]       instruction_in,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic [15:0]       fetch_count
);

    localparam logic [2:0]  c_st_boot   = 3'd0;
    localparam logic [2:0]  c_st_run    = 3'd1;
    localparam logic [2:0]  c_st_drain  = 3'd2;
    localparam logic [2:0]  c_st_halted = 3'd3;
    localparam logic [2:0]  c_st_fault  = 3'd4;

    localparam logic [31:0] c_ecall     = 32'h0000_0073;
    localparam logic [31:0] c_ebreak    = 32'h0010_0073;
    localparam logic [15:0] c_count_max = 16'hFFFF;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic              r_halted;
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_pc;
    logic [15:0]       r_fetch_count;

    logic w_cap;
    logic w_accept;
    logic w_is_sys;
    logic w_redir_aligned;
    logic w_redir_active;

    // The output register may load when empty or when being drained this cycle
    assign w_cap           = !r_inst_valid || inst_ready;
    assign w_accept        = r_inst_valid && inst_ready;
    assign w_is_sys        = (instruction_in == c_ecall) || (instruction_in == c_ebreak);
    assign w_redir_aligned = (redirect_pc[1:0] == 2'b00);
    // Redirects are honoured only while fetch is live
    assign w_redir_active  = redirect_valid && ((r_state == c_st_run) || (r_state == c_st_drain));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect outranks capture, stall and drain completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_boot: begin
                w_next_state = c_st_run;
            end
            c_st_run: begin
                if (w_redir_active) begin
                    w_next_state = w_redir_aligned ? c_st_run : c_st_fault;
                end else if (w_cap && w_is_sys) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_redir_active) begin
                    w_next_state = w_redir_aligned ? c_st_run : c_st_fault;
                end else if (w_accept) begin
                    w_next_state = c_st_halted;
                end
            end
            c_st_halted: begin
                w_next_state = c_st_halted;
            end
            c_st_fault: begin
                w_next_state = c_st_fault;
            end
            default: begin
                w_next_state = c_st_boot;
            end
        endcase
    end

    // PC, output register and sticky status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_pc   <= '0;
        end else if (w_redir_active) begin
            // Any instruction still sitting in the output register is dropped
            r_inst_valid <= 1'b0;
            if (w_redir_aligned) begin
                r_pc <= redirect_pc;
            end else begin
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_pc;
            end
        end else if (r_state == c_st_run) begin
            if (w_cap) begin
                r_inst       <= instruction_in;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
                // A system instruction freezes the PC on itself
                if (!w_is_sys) begin
                    r_pc <= r_pc + ADDR_W'(4);
                end
            end
        end else if (r_state == c_st_drain) begin
            if (w_accept) begin
                r_inst_valid <= 1'b0;
                r_halted     <= 1'b1;
            end
        end
    end

    // Saturating count of decoder handshakes, redirect cycles included
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 16'h0;
        end else if (w_accept && (r_fetch_count != c_count_max)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign address_out = r_pc;
    assign inst_valid  = r_inst_valid;
    assign inst_out    = r_inst;
    assign pc_out      = r_inst_pc;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed bench for pc_fetch_unit. Instance A starts at PC 0,
//               instance B starts at PC 8'hF8 for wrap and count saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic [31:0] mem [0:63];

    // Instance A signals
    logic        reset_a;
    logic [7:0]  addr_a;
    logic [31:0] instr_a;
    logic        redir_v_a;
    logic [7:0]  redir_pc_a;
    logic        valid_a;
    logic        ready_a;
    logic [31:0] inst_a;
    logic [7:0]  pc_a;
    logic        halted_a;
    logic        fault_a;
    logic [7:0]  fault_pc_a;
    logic [15:0] count_a;

    // Instance B signals
    logic        reset_b;
    logic [7:0]  addr_b;
    logic [31:0] instr_b;
    logic        redir_v_b;
    logic [7:0]  redir_pc_b;
    logic        valid_b;
    logic        ready_b;
    logic [31:0] inst_b;
    logic [7:0]  pc_b;
    logic        halted_b;
    logic        fault_b;
    logic [7:0]  fault_pc_b;
    logic [15:0] count_b;

    int n_cmp = 0;
    int n_bad = 0;

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Combinational instruction memory shared by both instances
    assign instr_a = mem[addr_a[7:2]];
    assign instr_b = mem[addr_b[7:2]];

    pc_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut_a (
        .clk            (clk),
        .reset          (reset_a),
        .address_out    (addr_a),
        .instruction_in (instr_a),
        .redirect_valid (redir_v_a),
        .redirect_pc    (redir_pc_a),
        .inst_valid     (valid_a),
        .inst_ready     (ready_a),
        .inst_out       (inst_a),
        .pc_out         (pc_a),
        .halted         (halted_a),
        .fault          (fault_a),
        .fault_pc       (fault_pc_a),
        .fetch_count    (count_a)
    );

    pc_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hF8)) u_dut_b (
        .clk            (clk),
        .reset          (reset_b),
        .address_out    (addr_b),
        .instruction_in (instr_b),
        .redirect_valid (redir_v_b),
        .redirect_pc    (redir_pc_b),
        .inst_valid     (valid_b),
        .inst_ready     (ready_b),
        .inst_out       (inst_b),
        .pc_out         (pc_b),
        .halted         (halted_b),
        .fault          (fault_b),
        .fault_pc       (fault_pc_b),
        .fetch_count    (count_b)
    );

    // Advance one rising edge and settle 1 unit past it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset instance A for two edges, then release; next edge is BOOT->RUN
    task automatic reset_a_seq;
        reset_a    = 1'b1;
        redir_v_a  = 1'b0;
        redir_pc_a = 8'h00;
        ready_a    = 1'b1;
        tick();
        tick();
        reset_a = 1'b0;
    endtask

    task automatic test_reset;
        reset_a_seq();
        n_cmp++; if (addr_a !== 8'h00)  begin n_bad++; $display("FAIL rst_addr got %h exp 00", addr_a); end
        n_cmp++; if (valid_a !== 1'b0)  begin n_bad++; $display("FAIL rst_valid got %b exp 0", valid_a); end
        n_cmp++; if (inst_a !== 32'h0)  begin n_bad++; $display("FAIL rst_inst got %h exp 0", inst_a); end
        n_cmp++; if (pc_a !== 8'h00)    begin n_bad++; $display("FAIL rst_pc_out got %h exp 00", pc_a); end
        n_cmp++; if (halted_a !== 1'b0 || fault_a !== 1'b0) begin n_bad++; $display("FAIL rst_flags got h%b f%b exp 0 0", halted_a, fault_a); end
        n_cmp++; if (fault_pc_a !== 8'h00 || count_a !== 16'h0) begin n_bad++; $display("FAIL rst_fpc_cnt got %h %h exp 00 0000", fault_pc_a, count_a); end
    endtask

    task automatic test_boot_stream;
        tick(); // E1: BOOT -> RUN, nothing captured
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL boot_valid got %b exp 0", valid_a); end
        n_cmp++; if (addr_a !== 8'h00) begin n_bad++; $display("FAIL boot_addr got %h exp 00", addr_a); end
        tick(); // E2: first capture
        n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b exp 1", valid_a); end
        n_cmp++; if (pc_a !== 8'h00 || inst_a !== 32'h1000_0000) begin n_bad++; $display("FAIL first_inst got %h/%h exp 00/10000000", pc_a, inst_a); end
        n_cmp++; if (addr_a !== 8'h04) begin n_bad++; $display("FAIL first_addr got %h exp 04", addr_a); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (pc_a !== 8'(4 * i) || inst_a !== (32'h1000_0000 + 32'(i))) begin n_bad++; $display("FAIL stream_%0d got %h/%h exp %h/%h", i, pc_a, inst_a, 8'(4 * i), 32'h1000_0000 + 32'(i)); end
            n_cmp++; if (count_a !== 16'(i)) begin n_bad++; $display("FAIL stream_cnt_%0d got %0d exp %0d", i, count_a, i); end
        end
        tick();
        n_cmp++; if (count_a !== 16'd5 || pc_a !== 8'h14) begin n_bad++; $display("FAIL five_accepts got cnt %0d pc %h exp 5 14", count_a, pc_a); end
    endtask

    task automatic test_stall;
        reset_a_seq();
        tick(); tick(); tick(); tick(); // pc_out 0,4,8 -> after 4th edge pc_out = 8
        n_cmp++; if (pc_a !== 8'h08 || addr_a !== 8'h0C) begin n_bad++; $display("FAIL pre_stall got pc %h addr %h exp 08 0C", pc_a, addr_a); end
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pc_a !== 8'h08 || inst_a !== 32'h1000_0002 || addr_a !== 8'h0C || valid_a !== 1'b1) begin n_bad++; $display("FAIL stall_hold_%0d got %h/%h/%h/%b exp 08/10000002/0C/1", i, pc_a, inst_a, addr_a, valid_a); end
        end
        ready_a = 1'b1;
        tick();
        n_cmp++; if (pc_a !== 8'h0C || inst_a !== 32'h1000_0003 || count_a !== 16'd3) begin n_bad++; $display("FAIL stall_release got %h/%h/%0d exp 0C/10000003/3", pc_a, inst_a, count_a); end
    endtask

    task automatic test_redirect;
        // Continues from stall: pc_out 0C valid, address 10
        redir_v_a  = 1'b1;
        redir_pc_a = 8'h40;
        tick();
        redir_v_a = 1'b0;
        n_cmp++; if (count_a !== 16'd4) begin n_bad++; $display("FAIL redir_count got %0d exp 4", count_a); end
        n_cmp++; if (valid_a !== 1'b0 || addr_a !== 8'h40) begin n_bad++; $display("FAIL redir_bubble got %b/%h exp 0/40", valid_a, addr_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b1 || pc_a !== 8'h40 || inst_a !== 32'h1000_0010) begin n_bad++; $display("FAIL redir_target got %b/%h/%h exp 1/40/10000010", valid_a, pc_a, inst_a); end
        n_cmp++; if (count_a !== 16'd4) begin n_bad++; $display("FAIL redir_count2 got %0d exp 4", count_a); end
    endtask

    task automatic test_halt;
        mem[4] = 32'h0000_0073;
        reset_a_seq();
        tick(); tick(); tick(); tick(); tick(); // pc_out 0,4,8,C
        tick(); // captures ECALL at 0x10
        n_cmp++; if (pc_a !== 8'h10 || inst_a !== 32'h0000_0073 || valid_a !== 1'b1) begin n_bad++; $display("FAIL ecall_cap got %h/%h/%b exp 10/00000073/1", pc_a, inst_a, valid_a); end
        n_cmp++; if (addr_a !== 8'h10 || halted_a !== 1'b0) begin n_bad++; $display("FAIL ecall_hold got %h/%b exp 10/0", addr_a, halted_a); end
        tick();
        n_cmp++; if (halted_a !== 1'b1 || valid_a !== 1'b0 || addr_a !== 8'h10) begin n_bad++; $display("FAIL halted got %b/%b/%h exp 1/0/10", halted_a, valid_a, addr_a); end
        n_cmp++; if (count_a !== 16'd5) begin n_bad++; $display("FAIL halt_count got %0d exp 5", count_a); end
        redir_v_a  = 1'b1;
        redir_pc_a = 8'h40;
        tick(); tick();
        redir_v_a = 1'b0;
        n_cmp++; if (addr_a !== 8'h10 || valid_a !== 1'b0 || halted_a !== 1'b1 || fault_a !== 1'b0) begin n_bad++; $display("FAIL halt_redir got %h/%b/%b/%b exp 10/0/1/0", addr_a, valid_a, halted_a, fault_a); end
        mem[4] = 32'h1000_0004;
    endtask

    task automatic test_fault;
        reset_a_seq();
        tick(); tick(); // pc_out 0 valid, address 4
        redir_v_a  = 1'b1;
        redir_pc_a = 8'h22;
        tick();
        n_cmp++; if (fault_a !== 1'b1 || fault_pc_a !== 8'h22 || valid_a !== 1'b0) begin n_bad++; $display("FAIL fault got %b/%h/%b exp 1/22/0", fault_a, fault_pc_a, valid_a); end
        n_cmp++; if (addr_a !== 8'h04 || count_a !== 16'd1) begin n_bad++; $display("FAIL fault_pc_hold got %h/%0d exp 04/1", addr_a, count_a); end
        redir_pc_a = 8'h40;
        tick();
        redir_v_a = 1'b0;
        n_cmp++; if (addr_a !== 8'h04 || fault_a !== 1'b1 || fault_pc_a !== 8'h22 || valid_a !== 1'b0) begin n_bad++; $display("FAIL fault_sticky got %h/%b/%h/%b exp 04/1/22/0", addr_a, fault_a, fault_pc_a, valid_a); end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        n_cmp++; if (fault_a !== 1'b0 || fault_pc_a !== 8'h00 || addr_a !== 8'h00 || count_a !== 16'h0) begin n_bad++; $display("FAIL fault_reset got %b/%h/%h/%0d exp 0/00/00/0", fault_a, fault_pc_a, addr_a, count_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL fault_reboot got %b exp 0", valid_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b1 || pc_a !== 8'h00) begin n_bad++; $display("FAIL fault_rerun got %b/%h exp 1/00", valid_a, pc_a); end
    endtask

    task automatic test_wrap_saturate;
        logic [7:0] exp_pc [0:3];
        exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
        reset_b = 1'b0;
        tick(); // BOOT
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (pc_b !== exp_pc[i] || inst_b !== (32'h1000_0000 + 32'(exp_pc[i] >> 2)) || valid_b !== 1'b1) begin n_bad++; $display("FAIL wrap_%0d got %h/%h exp %h", i, pc_b, inst_b, exp_pc[i]); end
        end
        n_cmp++; if (count_b !== 16'd3) begin n_bad++; $display("FAIL wrap_count got %0d exp 3", count_b); end
        for (int i = 0; i < 65531; i++) tick();
        n_cmp++; if (count_b !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre got %h exp FFFE", count_b); end
        tick();
        n_cmp++; if (count_b !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h exp FFFF", count_b); end
        tick(); tick();
        n_cmp++; if (count_b !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h exp FFFF", count_b); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        reset_a    = 1'b1;
        ready_a    = 1'b1;
        redir_v_a  = 1'b0;
        redir_pc_a = 8'h00;
        reset_b    = 1'b1;
        ready_b    = 1'b1;
        redir_v_b  = 1'b0;
        redir_pc_b = 8'h00;

        test_reset();
        test_boot_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_wrap_saturate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
